// File: rtl/axi_rd_ch_sched.sv
// axi_rd_ch_sched: shares one AXI read master among CH_NUM read channels in round-robin order.
// It tracks a linear or ping-pong read address per channel and routes returned beats to their owner.
module axi_rd_ch_sched #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 128,
  parameter int LVL_WIDTH  = 12
) (
  input  logic                         ui_clk,
  input  logic                         ui_rst_n,
  input  logic [CH_NUM-1:0]            ch_enable,
  input  logic [CH_NUM-1:0]            ch_restart,
  input  logic [CH_NUM-1:0]            ch_pingpong,
  input  logic [CH_NUM-1:0]            ch_wr_bank,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_b_addr,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_e_addr,
  input  logic [CH_NUM*LVL_WIDTH-1:0]  ch_fifo_level,
  output logic                         rd_burst_req,
  output logic [ADDR_WIDTH-1:0]        rd_burst_addr,
  output logic [9:0]                   rd_burst_len,
  input  logic                         rd_ready,
  input  logic                         rd_fifo_we,
  input  logic [DATA_WIDTH-1:0]        rd_fifo_data,
  input  logic                         rd_burst_finish,
  output logic [CH_NUM-1:0]            ch_fifo_we,
  output logic [DATA_WIDTH-1:0]        ch_fifo_data,
  output logic [CH_NUM-1:0]            ch_rd_bank,
  output logic [CH_NUM-1:0]            ch_len_err
);

  // state | meaning
  // IDLE  | wait for an eligible channel while the read master is idle
  // REQ   | one-cycle burst request for the granted channel
  // WAIT  | count and route returned beats until burst finish
  // UPD   | advance or restart the granted channel's address
  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPD} state_t;

  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 32);
  localparam logic [LVL_WIDTH-1:0]  LVL_MAX   = LVL_WIDTH'(FIFO_DEPTH - 2 * BURST_LEN);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      CNT_SAT   = '1;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_q, gnt_q, gnt_sel;
  logic                  gnt_found, start_grant;
  int                    idx;
  logic [ADDR_WIDTH-1:0] b_addr [CH_NUM];
  logic [ADDR_WIDTH-1:0] e_addr [CH_NUM];
  logic [ADDR_WIDTH-1:0] addr_q [CH_NUM];
  logic [CH_NUM-1:0]     eligible, armed_q, restart_pend_q, restart_q, rst_edge;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic [ADDR_WIDTH-1:0] g_b, g_e, g_addr, bank_end, nxt_addr;
  logic                  g_bank, nxt_bank, last_step, drop_beat;

  assign rd_burst_len = 10'(BURST_LEN - 1);
  assign rst_edge     = ch_restart & ~restart_q;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      b_addr[i]   = ch_b_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      e_addr[i]   = ch_e_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      eligible[i] = ch_enable[i] & ~restart_pend_q[i] &
                    (ch_fifo_level[i*LVL_WIDTH +: LVL_WIDTH] <= LVL_MAX);
    end
  end

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    idx       = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (int'(rr_q) + k) % CH_NUM;
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_sel   = PTR_W'(idx);
      end
    end
  end

  assign start_grant = (state_q == IDLE) && gnt_found && rd_ready;

  // Bank 1 of a ping-pong channel spans [e, 2e-b), the mirror of bank 0.
  always_comb begin
    g_b       = b_addr[gnt_q];
    g_e       = e_addr[gnt_q];
    g_addr    = addr_q[gnt_q];
    g_bank    = ch_rd_bank[gnt_q];
    drop_beat = restart_pend_q[gnt_q] | rst_edge[gnt_q];
    bank_end  = (ch_pingpong[gnt_q] && g_bank) ? (g_e + g_e - g_b) : g_e;
    last_step = (g_addr >= bank_end - ADDR_STEP);
    nxt_bank  = 1'b0;
    nxt_addr  = g_addr + ADDR_STEP;
    if (ch_pingpong[gnt_q]) begin
      nxt_bank = g_bank;
      if (last_step) begin
        nxt_bank = ~ch_wr_bank[gnt_q];
        nxt_addr = nxt_bank ? g_e : g_b;
      end
    end else if (last_step) begin
      nxt_addr = g_b;
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    rd_burst_req = 1'b0;
    ch_len_err   = '0;
    case (state_q)
      IDLE: if (start_grant) state_d = REQ;
      REQ: begin
        rd_burst_req = 1'b1;
        state_d      = WAIT;
      end
      WAIT: if (rd_burst_finish) state_d = UPD;
      UPD: begin
        state_d = IDLE;
        if (beat_cnt_q != CNT_FULL && !drop_beat) ch_len_err[gnt_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      rr_q           <= '0;
      gnt_q          <= '0;
      beat_cnt_q     <= '0;
      rd_burst_addr  <= '0;
      ch_fifo_we     <= '0;
      ch_fifo_data   <= '0;
      ch_rd_bank     <= '0;
      restart_q      <= '0;
      restart_pend_q <= '0;
      armed_q        <= '0;
      for (int i = 0; i < CH_NUM; i++) addr_q[i] <= '0;
    end else begin
      restart_q    <= ch_restart;
      ch_fifo_data <= rd_fifo_data;
      ch_fifo_we   <= '0;
      if (state_q == WAIT && rd_fifo_we) begin
        if (!drop_beat) ch_fifo_we[gnt_q] <= 1'b1;
        if (beat_cnt_q != CNT_SAT) beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (start_grant) begin
        gnt_q         <= gnt_sel;
        rr_q          <= (gnt_sel == PTR_W'(CH_NUM - 1)) ? '0 : gnt_sel + 1'b1;
        beat_cnt_q    <= '0;
        rd_burst_addr <= (armed_q[gnt_sel] && !rst_edge[gnt_sel]) ? addr_q[gnt_sel]
                                                                  : b_addr[gnt_sel];
      end
      for (int i = 0; i < CH_NUM; i++) begin
        if (state_q == UPD && gnt_q == PTR_W'(i)) begin
          if (restart_pend_q[i] || rst_edge[i]) begin
            addr_q[i]     <= b_addr[i];
            ch_rd_bank[i] <= 1'b0;
          end else begin
            addr_q[i]     <= nxt_addr;
            ch_rd_bank[i] <= nxt_bank;
          end
          restart_pend_q[i] <= 1'b0;
        end else if ((state_q == REQ || state_q == WAIT) && gnt_q == PTR_W'(i)) begin
          if (rst_edge[i]) restart_pend_q[i] <= 1'b1;
        end else if (rst_edge[i] || (start_grant && gnt_sel == PTR_W'(i) && !armed_q[i])) begin
          addr_q[i]     <= b_addr[i];
          ch_rd_bank[i] <= 1'b0;
          armed_q[i]    <= 1'b1;
        end
      end
    end
  end

endmodule
